cic_dec_ctl: RTL and testbench

- Sequencer for the 4-stage CIC decimator.
- Generates the decimator's 2-clock-wide output-rate enable from a programmable decimation ratio, and drives the decimator's synchronous reset to flush on enable and on rate change.
- Suppresses the settling transient by discarding the first SETTLE decimated outputs, then converts the decimator's 2-clock valid into a 1-clock sample strobe for downstream logic.
- Sits between the register/config interface and the CIC datapath.

---
 rtl/cic_pkg.sv | 18 +
 rtl/cic_dec_ctl_if.sv | 24 ++
 rtl/cic_rate_gen.sv | 26 ++
 rtl/cic_dec_ctl.sv | 106 ++++++++++
 tb/tb_cic_dec_ctl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator sequencer and datapath:
// state encoding, default/minimum ratios and the stage count.
package cic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } cic_state_t;

    localparam int CIC_NUM_STAGES = 4;
    // Outputs discarded after a flush: one per integrator/comb stage plus one.
    localparam int CIC_SETTLE     = CIC_NUM_STAGES + 1;
    localparam int CIC_DEF_RATE   = 256;
    localparam int CIC_MIN_RATE   = 4;

endpackage

// File: rtl/cic_dec_ctl_if.sv
// Config, decimator-control and sample-strobe signals of the CIC sequencer.
interface cic_dec_ctl_if #(
    parameter int RW = 12
);
    logic          enable;
    logic [RW-1:0] cfg_rate;
    logic          cfg_wr;
    logic          cic_reset;
    logic          cic_ena_out;
    logic          cic_valid;
    logic          out_valid;
    logic [RW-1:0] rate_cur;
    logic          settled;

    modport master (
        output enable, cfg_rate, cfg_wr, cic_valid,
        input  cic_reset, cic_ena_out, out_valid, rate_cur, settled
    );

    modport slave (
        input  enable, cfg_rate, cfg_wr, cic_valid,
        output cic_reset, cic_ena_out, out_valid, rate_cur, settled
    );
endinterface

// File: rtl/cic_rate_gen.sv
// Output-rate counter: dcnt runs 0..rate-1 and ena_out is a registered
// 2-clock pulse at dcnt 0 and 1; clr holds both at zero.
module cic_rate_gen #(
    parameter int RW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [RW-1:0] rate,
    output logic          ena_out
);
    logic [RW-1:0] dcnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt_reg <= '0;
            ena_out  <= 1'b0;
        end else if (clr) begin
            dcnt_reg <= '0;
            ena_out  <= 1'b0;
        end else begin
            ena_out  <= (dcnt_reg <= RW'(1));
            dcnt_reg <= (dcnt_reg == rate - RW'(1)) ? '0 : dcnt_reg + RW'(1);
        end
    end
endmodule

// File: rtl/cic_dec_ctl.sv
// CIC decimator sequencer: flush on enable/rate change, discard the settling
// outputs, then turn the decimator's 2-clock valid into a 1-clock strobe.
module cic_dec_ctl
    import cic_pkg::*;
#(
    parameter int RW        = 12,
    parameter int DEF_RATE  = CIC_DEF_RATE,
    parameter int MIN_RATE  = CIC_MIN_RATE,
    parameter int FLUSH_CYC = 8,
    parameter int SETTLE    = CIC_SETTLE
) (
    input  logic         clk,
    input  logic         reset,
    cic_dec_ctl_if.slave bus
);
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [FW-1:0] FLUSH_LAST  = FW'(FLUSH_CYC - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE);

    cic_state_t    state_reg, state_next;
    logic [FW-1:0] fcnt_reg, fcnt_next;
    logic [SW-1:0] scnt_reg;
    logic [RW-1:0] rate_cur_reg, pend_rate_reg, wr_rate, rate_src;
    logic          pend_reg, valid_d_reg, out_valid_reg;
    logic          rise, flush_load, idle_copy, rate_clr;

    assign wr_rate  = (bus.cfg_rate < RW'(MIN_RATE)) ? RW'(MIN_RATE) : bus.cfg_rate;
    assign rate_src = bus.cfg_wr ? wr_rate : pend_rate_reg;
    assign rise     = bus.cic_valid & ~valid_d_reg;

    always_comb begin
        state_next = state_reg;
        if (!bus.enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   state_next = ST_FLUSH;
                ST_FLUSH:  if (!bus.cfg_wr && fcnt_reg == FLUSH_LAST) state_next = ST_SETTLE;
                ST_SETTLE: begin
                    if (bus.cfg_wr)                              state_next = ST_FLUSH;
                    else if (rise && scnt_reg == SETTLE_LAST)    state_next = ST_RUN;
                end
                ST_RUN:    if (bus.cfg_wr) state_next = ST_FLUSH;
                default:   state_next = ST_IDLE;
            endcase
        end

        fcnt_next = '0;
        if (state_reg == ST_FLUSH && state_next == ST_FLUSH && !bus.cfg_wr)
            fcnt_next = fcnt_reg + FW'(1);

        // A new ratio takes effect when a flush starts or restarts, never mid-period.
        flush_load = (state_next == ST_FLUSH) && (state_reg != ST_FLUSH || bus.cfg_wr)
                     && (bus.cfg_wr || pend_reg);
        idle_copy  = (state_reg == ST_IDLE) && pend_reg;
        rate_clr   = (state_reg inside {ST_IDLE, ST_FLUSH}) || (state_next inside {ST_IDLE, ST_FLUSH});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            fcnt_reg      <= '0;
            scnt_reg      <= '0;
            rate_cur_reg  <= RW'(DEF_RATE);
            pend_rate_reg <= RW'(DEF_RATE);
            pend_reg      <= 1'b0;
            valid_d_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            fcnt_reg    <= fcnt_next;
            valid_d_reg <= bus.cic_valid;
            if (bus.cfg_wr)
                pend_rate_reg <= wr_rate;
            if (flush_load) begin
                rate_cur_reg <= rate_src;
                pend_reg     <= 1'b0;
            end else begin
                if (idle_copy)
                    rate_cur_reg <= pend_rate_reg;
                pend_reg <= bus.cfg_wr | (pend_reg & ~idle_copy);
            end
            if (state_reg inside {ST_IDLE, ST_FLUSH})
                scnt_reg <= '0;
            else if (rise && scnt_reg != SETTLE_MAX)
                scnt_reg <= scnt_reg + SW'(1);
            // Edges that coincide with leaving RUN are dropped.
            out_valid_reg <= rise && (state_reg == ST_RUN) && (state_next == ST_RUN);
        end
    end

    cic_rate_gen #(.RW(RW)) u_rate_gen (
        .clk     (clk),
        .reset   (reset),
        .clr     (rate_clr),
        .rate    (rate_cur_reg),
        .ena_out (bus.cic_ena_out)
    );

    assign bus.cic_reset = (state_reg == ST_IDLE) || (state_reg == ST_FLUSH);
    assign bus.settled   = (state_reg == ST_RUN);
    assign bus.out_valid = out_valid_reg;
    assign bus.rate_cur  = rate_cur_reg;
endmodule

// File: tb/tb_cic_dec_ctl.sv
// Self-checking bench for cic_dec_ctl; the decimator is modelled as a
// zero-latency valid that follows cic_ena_out.
module tb_cic_dec_ctl;
    localparam int RW     = 12;
    localparam int SETTLE = 5;

    logic clk;
    logic reset;
    int   errors, checks;
    int   cyc, edges, ov_seen;
    int   exp_q[$];

    cic_dec_ctl_if #(.RW(RW)) bus ();

    cic_dec_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", tag, act, cyc);
        end
    endtask

    // One clock: drive the decimator valid, predict strobes, sample outputs.
    task automatic tick();
        logic v;
        v = bus.cic_ena_out;
        if (bus.cfg_wr || !bus.enable || reset) begin
            edges = 0;
        end else if (v && !bus.cic_valid) begin
            edges++;
            if (edges > SETTLE) exp_q.push_back(cyc + 1);
        end
        bus.cic_valid = v;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() != 0 && exp_q[0] == cyc) begin
            void'(exp_q.pop_front());
            check("out_valid", int'(bus.out_valid), 1);
        end else if (bus.out_valid) begin
            check("out_valid_unexpected", int'(bus.out_valid), 0);
        end
        if (bus.out_valid) ov_seen++;
        bus.cfg_wr = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_reset(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!bus.cic_reset) break;
            n++;
        end
    endtask

    task automatic wait_settled(input int bound);
        for (int i = 0; i < bound && !bus.settled; i++) tick();
        check("settled", int'(bus.settled), 1);
    endtask

    task automatic ena_period(output int p);
        int t0;
        logic prev;
        p = -1;
        t0 = -1;
        prev = bus.cic_ena_out;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.cic_ena_out && !prev) begin
                if (t0 < 0) t0 = cyc;
                else begin
                    p = cyc - t0;
                    break;
                end
            end
            prev = bus.cic_ena_out;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cic_reset"}, int'(bus.cic_reset), 1);
        check({tag, "_ena"}, int'(bus.cic_ena_out), 0);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_settled"}, int'(bus.settled), 0);
    endtask

    initial begin
        int n, p, hi;
        logic [7:0] pat;
        errors = 0; checks = 0; cyc = 0; edges = 0; ov_seen = 0;
        reset = 1'b1;
        bus.enable = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_rate = '0; bus.cic_valid = 1'b0;
        ticks(3);
        check_idle("reset");
        check("reset_rate", int'(bus.rate_cur), 256);
        reset = 1'b0;

        // Enable at default ratio 256
        bus.enable = 1'b1;
        count_reset(n);
        check("flush_len_256", n, 8);
        tick();
        check("ena_first", int'(bus.cic_ena_out), 1);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (bus.cic_ena_out) hi++;
        end
        check("ena_high_per_256", hi, 2);
        wait_settled(2000);
        ov_seen = 0;
        ticks(300);
        check("ov_after_settle", ov_seen, 1);

        // Ratio below minimum is clamped to 4
        bus.cfg_rate = 12'd2; bus.cfg_wr = 1'b1;
        count_reset(n);
        check("flush_len_rate4", n, 8);
        check("rate_clamped", int'(bus.rate_cur), 4);
        for (int i = 0; i < 8; i++) begin
            tick();
            pat = {pat[6:0], bus.cic_ena_out};
        end
        check("ena_pattern_1100", int'(pat), 8'hCC);
        wait_settled(100);
        ov_seen = 0;
        ticks(40);
        check("ov_count_rate4", ov_seen, 10);

        // Back to 256, then change to 64 mid-period
        bus.cfg_rate = 12'd256; bus.cfg_wr = 1'b1;
        count_reset(n);
        wait_settled(2000);
        ticks(100);
        bus.cfg_rate = 12'd64; bus.cfg_wr = 1'b1;
        count_reset(n);
        check("flush_len_64", n, 8);
        check("rate_64", int'(bus.rate_cur), 64);
        ena_period(p);
        check("period_64", p, 64);
        wait_settled(600);
        ticks(200);

        // Two writes during a flush; last one wins and restarts the flush
        bus.cfg_rate = 12'd100; bus.cfg_wr = 1'b1;
        ticks(3);
        bus.cfg_rate = 12'd50; bus.cfg_wr = 1'b1;
        count_reset(n);
        check("flush_restart_len", n, 8);
        check("rate_50", int'(bus.rate_cur), 50);
        ena_period(p);
        check("period_50", p, 50);

        // Drop enable during SETTLE
        bus.enable = 1'b0;
        tick();
        check_idle("drop_settle");
        bus.cfg_rate = 12'd300; bus.cfg_wr = 1'b1;
        ticks(2);
        check("idle_rate_copy", int'(bus.rate_cur), 300);
        bus.enable = 1'b1;
        count_reset(n);
        check("reenable_flush_len", n, 8);
        wait_settled(2500);
        ticks(50);

        // Drop enable during RUN
        bus.enable = 1'b0;
        tick();
        check_idle("drop_run");
        bus.cfg_rate = 12'd40; bus.cfg_wr = 1'b1;
        ticks(3);
        bus.enable = 1'b1;
        count_reset(n);
        check("reenable2_flush_len", n, 8);
        wait_settled(500);
        ticks(120);

        // Asynchronous reset between clock edges
        ticks(7);
        #3;
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        check("async_reset_rate", int'(bus.rate_cur), 256);
        exp_q.delete();
        edges = 0;
        ticks(2);
        reset = 1'b0;
        count_reset(n);
        check("post_reset_flush_len", n, 8);
        ticks(20);
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
